// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, default reset PC and the
// fetch-buffer entry type.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One instruction-buffer entry: the byte address and the word fetched there.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Decode-side instruction handshake.
// Handshake: the fetch side raises inst_valid while the head entry is valid
// and holds inst_pc/inst_data stable until the cycle inst_ready is also 1;
// that cycle (inst_valid & inst_ready) transfers the head.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            inst_valid;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO of fetch entries with flush. The head
// is presented on the decode handshake; a flush empties it and wins over
// any pop in the same cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output logic [$clog2(DEPTH):0]   count,
  fetch_unit_if.master             head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;

  // Head transfer; ignored while flushing.
  assign pop = head.inst_valid & head.inst_ready & ~flush;

  assign head.inst_valid = (count != '0);
  assign head.inst_pc    = mem[rd_ptr].pc;
  assign head.inst_data  = mem[rd_ptr].insn;

  // Entry storage; data needs no reset since validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks a word-aligned PC through instruction memory,
// buffers fetched words for decode and handles branch/jump redirects.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CNT_W-1:0] count;
  logic            pop;
  logic            push;
  fetch_entry_t    wdata;

  fetch_unit_if head_if ();

  assign head_if.inst_ready = inst_ready;
  assign inst_valid         = head_if.inst_valid;
  assign inst_data          = head_if.inst_data;
  assign inst_pc            = head_if.inst_pc;

  assign imem_addr = fetch_pc;

  // A full buffer can still accept a word when the head leaves this cycle.
  assign pop   = inst_valid & inst_ready;
  assign push  = ~redirect_valid & ((count < CNT_W'(BUF_DEPTH)) | pop);
  assign wdata = '{pc: fetch_pc, insn: imem_rdata};

  // Fetch PC: redirect target wins, otherwise step one word per push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= align_pc(RESET_PC);
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .flush (redirect_valid),
    .wdata (wdata),
    .count (count),
    .head  (head_if.master)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the byte address of the first fetch after reset.
REQ-002 SHALL provide parameter BUF_DEPTH, default 2, meaning the number of instruction-buffer entries (legal values: power of two, >=2).
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port imem_addr, output, 32 bits: byte address presented to instruction memory.
REQ-006 SHALL provide port imem_rdata, input, 32 bits: combinational memory data for imem_addr, valid in the same cycle.
REQ-007 SHALL provide port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL provide port redirect_pc, input, 32 bits: redirect target byte address.
REQ-009 SHALL provide port inst_valid, output, 1 bit: buffer head holds a valid instruction.
REQ-010 SHALL provide port inst_data, output, 32 bits: instruction word at buffer head.
REQ-011 SHALL provide port inst_pc, output, 32 bits: byte address of inst_data.
REQ-012 SHALL provide port inst_ready, input, 1 bit: decode accepts the head this cycle.

Function
REQ-013 SHALL drive imem_addr = fetch_pc combinationally at all times, where fetch_pc is an internal 32-bit register with bits [1:0] always 0.
REQ-014 SHALL define pop = inst_valid & inst_ready and push = !redirect_valid & (count < BUF_DEPTH | pop).
REQ-015 On push SHALL write {fetch_pc, imem_rdata} to the buffer tail and set fetch_pc <= fetch_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-016 On pop SHALL advance the head; inst_pc and inst_data SHALL then present the next entry, in order.
REQ-017 Simultaneous push and pop SHALL leave count unchanged, including when full, so sustained throughput is one instruction per cycle.
REQ-018 SHALL drive inst_valid = (count != 0); inst_data and inst_pc SHALL be don't-care when inst_valid = 0.
REQ-019 SHALL keep the head entry and inst_valid stable while inst_valid = 1 and inst_ready = 0.
REQ-020 On redirect_valid = 1 SHALL discard all buffer entries (count <= 0), ignore any pop in that cycle, suppress push, and set fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-021 After a redirect in cycle N, inst_valid SHALL be 0 in cycle N+1, and the target instruction SHALL be valid in cycle N+2.
REQ-022 Consecutive redirects SHALL each take effect; only the last one determines fetch_pc.
REQ-023 The head-to-decode latency SHALL be one cycle: an instruction fetched in cycle N is presentable in cycle N+1.
REQ-024 Buffer pointers SHALL wrap modulo BUF_DEPTH; count SHALL range 0..BUF_DEPTH and never overflow or underflow.

Reset
REQ-025 While rst_n = 0, SHALL hold fetch_pc = RESET_PC, count = 0, and pointers = 0, so inst_valid = 0 and imem_addr = RESET_PC.
REQ-026 Reset assertion mid-operation SHALL take effect immediately (asynchronously) and discard all buffered instructions.
REQ-027 In the first rising edge after rst_n deasserts, SHALL push the instruction at RESET_PC; inst_valid SHALL be 1 in the following cycle.

Structure
REQ-028 A shared package (cpu_pkg) SHALL hold XLEN = 32, ILEN = 32, the default RESET_PC, and a packed typedef fetch_entry_t {pc, insn}.
REQ-029 SHALL instantiate one sub-module, fetch_fifo (parameterised depth, push/pop/flush, count output), holding fetch_entry_t entries; the PC and redirect logic SHALL live in fetch_unit.
REQ-030 SHALL contain no memory array for instructions; all instruction data comes from imem_rdata.

Verification
REQ-031 Reset then inst_ready held at 1, memory word i = 0x1000_0000+i -> inst_pc = 0, 4, 8, ... and inst_data = 0x1000_0000, 0x1000_0001, ... one per cycle with no gaps.
REQ-032 inst_ready = 0 for 5 cycles after reset -> count saturates at 2, fetch_pc stops at 0x8, and the head stays at pc = 0x0; on release, pc 0x0, 0x4, 0x8 follow in order.
REQ-033 redirect_valid pulsed with redirect_pc = 0x40 while the buffer is full -> inst_valid = 0 next cycle, then inst_pc = 0x40, 0x44, ...; no stale pc (0x0 to 0x8) appears.
REQ-034 redirect_pc = 0x0000_0047 -> next delivered inst_pc = 0x0000_0044.
REQ-035 Redirect to 0xFFFF_FFF8, ready = 1 -> inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 rst_n asserted asynchronously mid-stream with 2 entries buffered -> inst_valid drops before the next clock edge and imem_addr = RESET_PC; the stream restarts from RESET_PC after release.
